// File: rtl/lsu_mem_req_pkg.sv
// Shared definitions for the LSU memory request stage: funct3 codes, FSM states,
// the load-tracking record and the store byte-lane helpers.
package lsu_mem_req_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_FAULT = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] func3;
    logic [1:0] byte_addr;
  } lsu_track_t;

  // Any funct3 that is not a defined byte/half op falls back to a word access.
  function automatic lsu_size_e access_size(input logic is_store, input logic [2:0] func3);
    lsu_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      if (func3 == FNC_SB)      sz = SZ_BYTE;
      else if (func3 == FNC_SH) sz = SZ_HALF;
    end else begin
      if (func3 == FNC_LB || func3 == FNC_LBU)      sz = SZ_BYTE;
      else if (func3 == FNC_LH || func3 == FNC_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] store_we(input lsu_size_e sz, input logic [1:0] off);
    logic [3:0] we;
    case (sz)
      SZ_BYTE: we = 4'b0001 << off;
      SZ_HALF: we = 4'b0011 << {off[1], 1'b0};
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

  function automatic logic [31:0] store_wdata(input lsu_size_e sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_mem_req_track_pipe.sv
// Fixed-latency shift pipe carrying {valid, funct3, byte offset} of issued loads
// so they line up with the returning read data.
module lsu_load_track_pipe
  import lsu_mem_req_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_func3,
  input  logic [1:0] in_byte_addr,
  output logic       out_valid,
  output logic [2:0] out_func3,
  output logic [1:0] out_byte_addr
);

  lsu_track_t pipe_q [DEPTH];
  lsu_track_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = '{vld: in_valid, func3: in_func3, byte_addr: in_byte_addr};
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_valid     = pipe_q[DEPTH-1].vld;
  assign out_func3     = pipe_q[DEPTH-1].func3;
  assign out_byte_addr = pipe_q[DEPTH-1].byte_addr;

endmodule

// File: rtl/lsu_mem_req.sv
// Load/store request stage driving the data-memory port. Optional misaligned
// trap (FAULT state, fault/fault_addr) is built when LSU_MISALIGN_TRAP_EN is defined.
module lsu_mem_req
  import lsu_mem_req_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_func3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  dmem_en,
  output logic [3:0]            dmem_we,
  output logic [ADDR_WIDTH-3:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_func3,
  output logic [1:0]            rsp_byte_addr,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic                  fault_ack
);

  lsu_state_e            state_q, state_d;
  logic [3:0]            we_q, we_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            func3_q, func3_d;
  logic [1:0]            off_q, off_d;
  logic                  ready_raw, take, mem_accept;
  lsu_size_e             req_size;
  logic [1:0]            req_off;

  assign req_off  = req_addr[1:0];
  assign req_size = access_size(req_is_store, req_func3);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_store_d = is_store_q;
    func3_d    = func3_q;
    off_d      = off_q;
    ready_raw  = 1'b0;
    take       = 1'b0;
    mem_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_raw = 1'b1;
        take      = req_valid;
      end
      ST_ISSUE: begin
        ready_raw  = dmem_ready;
        mem_accept = dmem_ready;
        take       = dmem_ready & req_valid;
        if (dmem_ready && !req_valid) state_d = ST_IDLE;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      ST_FAULT: begin
        if (fault_ack) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A new request overwrites the port registers; while stalled they hold.
    if (take) begin
      state_d    = ST_ISSUE;
      addr_d     = req_addr[ADDR_WIDTH-1:2];
      is_store_d = req_is_store;
      func3_d    = req_func3;
      off_d      = req_off;
      we_d       = req_is_store ? store_we(req_size, req_off) : 4'b0000;
      wdata_d    = req_is_store ? store_wdata(req_size, req_wdata) : '0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (is_misaligned(req_size, req_off)) state_d = ST_FAULT;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      func3_q    <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_store_q <= is_store_d;
      func3_q    <= func3_d;
      off_q      <= off_d;
    end
  end

  // Gated by rst_n so req_ready reads 0 while reset is held.
  assign req_ready  = ready_raw & rst_n;
  assign dmem_en    = (state_q == ST_ISSUE);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  lsu_load_track_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_track (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (mem_accept & ~is_store_q),
    .in_func3      (func3_q),
    .in_byte_addr  (off_q),
    .out_valid     (rsp_valid),
    .out_func3     (rsp_func3),
    .out_byte_addr (rsp_byte_addr)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;

  always_comb begin
    fault_addr_d = fault_addr_q;
    if (take && is_misaligned(req_size, req_off)) fault_addr_d = req_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_addr_q <= '0;
    else        fault_addr_q <= fault_addr_d;
  end

  assign fault      = (state_q == ST_FAULT);
  assign fault_addr = fault_addr_q;
`else
  logic unused_fault_ack;
  assign unused_fault_ack = fault_ack;
  assign fault            = 1'b0;
  assign fault_addr       = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_req.sv
// Bench for lsu_mem_req: directed vector table, multi-cycle sequences, and a
// randomized run checked by a queue-based transaction model.
module tb_lsu_mem_req;

  localparam int LAT = 2;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        dmem_en, dmem_ready;
  logic [3:0]  dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        rsp_valid;
  logic [2:0]  rsp_func3;
  logic [1:0]  rsp_byte_addr;
  logic        fault, fault_ack;
  logic [31:0] fault_addr;

  lsu_mem_req #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_func3(req_func3), .req_addr(req_addr),
    .req_wdata(req_wdata), .dmem_en(dmem_en), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .rsp_valid(rsp_valid), .rsp_func3(rsp_func3), .rsp_byte_addr(rsp_byte_addr),
    .fault(fault), .fault_addr(fault_addr), .fault_ack(fault_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  off;
  } port_t;

  typedef struct {
    int         due;
    logic [2:0] f3;
    logic [1:0] off;
  } rsp_t;

  function automatic int acc_bytes(input logic st, input logic [2:0] f);
    if (st) return (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
    return (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic st, input logic [2:0] f, input logic [31:0] a);
    return (a % acc_bytes(st, f)) != 0;
  endfunction

  function automatic port_t model_req(input logic st, input logic [2:0] f,
                                      input logic [31:0] a, input logic [31:0] d);
    port_t p;
    int off, sz;
    off     = int'(a % 4);
    sz      = acc_bytes(st, f);
    p.waddr = a[31:2];
    p.ld    = !st;
    p.f3    = f;
    p.off   = a[1:0];
    p.we    = 4'h0;
    p.wdata = 32'h0;
    if (st) begin
      if (sz == 1) begin
        p.we = 4'(1 << off);       p.wdata = (d & 32'hFF) * 32'h01010101;
      end else if (sz == 2) begin
        p.we = 4'(3 << (off / 2 * 2)); p.wdata = (d & 32'hFFFF) * 32'h00010001;
      end else begin
        p.we = 4'hF;               p.wdata = d;
      end
    end
    return p;
  endfunction

  port_t       port_q[$];
  rsp_t        rsp_q[$];
  port_t       p, last_p, held, cur;
  rsp_t        r;
  bit          show_pend = 0, hold_pend = 0, acc_flag = 0, exp_v;
  bit          f_cur = 0, f_nxt;
  logic [31:0] f_addr = 0;
  int          cyc = 0;
  int          wr_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (dmem_en && dmem_ready && dmem_we != 4'h0) wr_cnt++;
    if (!rst_n) begin
      port_q.delete();
      rsp_q.delete();
      show_pend = 0; hold_pend = 0; acc_flag = 0; f_cur = 0;
      check("rst_ctl", {dmem_en, dmem_we, rsp_valid, rsp_func3, rsp_byte_addr, fault, req_ready}, 0);
      check("rst_data", {dmem_addr, dmem_wdata, fault_addr}, 0);
    end else begin
      cur = '{waddr: dmem_addr, we: dmem_we, wdata: dmem_wdata, ld: 1'b0, f3: 3'd0, off: 2'd0};
      check("fault", fault, f_cur);
      if (f_cur) check("fault_addr", fault_addr, f_addr);
      if (show_pend) begin
        check("issue_en", dmem_en, 1'b1);
        check("issue_addr", dmem_addr, last_p.waddr);
        check("issue_we", dmem_we, last_p.we);
      end
      if (hold_pend) begin
        check("hold_en", dmem_en, 1'b1);
        check("hold_port", {dmem_addr, dmem_we, dmem_wdata}, {held.waddr, held.we, held.wdata});
      end
      if (dmem_en && dmem_ready) begin
        if (port_q.size() == 0) begin
          total++;
          $display("FAIL port_unexpected: dmem accept of 0x%0h with nothing outstanding", dmem_addr);
        end else begin
          p = port_q.pop_front();
          check("port_addr", dmem_addr, p.waddr);
          check("port_we", dmem_we, p.we);
          if (!p.ld) check("port_wdata", dmem_wdata, p.wdata);
          else rsp_q.push_back('{cyc + LAT, p.f3, p.off});
        end
      end
      hold_pend = dmem_en && !dmem_ready;
      held      = cur;
      exp_v = (rsp_q.size() != 0) && (rsp_q[0].due == cyc);
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        r = rsp_q.pop_front();
        check("rsp_func3", rsp_func3, r.f3);
        check("rsp_byte_addr", rsp_byte_addr, r.off);
      end
      f_nxt     = f_cur && !fault_ack;
      acc_flag  = req_valid && req_ready;
      show_pend = 0;
      if (acc_flag) begin
        p = model_req(req_is_store, req_func3, req_addr, req_wdata);
        if (TRAP && model_mis(req_is_store, req_func3, req_addr)) begin
          f_nxt  = 1;
          f_addr = req_addr;
        end else begin
          port_q.push_back(p);
          last_p    = p;
          show_pend = 1;
        end
      end
      f_cur = f_nxt;
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  we;
    logic [31:0] ewd;
    logic [29:0] waddr;
    logic        mis;
  } vec_t;

  vec_t vt[13];

  task automatic drive(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req_valid    = 1'b1;
    req_is_store = st;
    req_func3    = f;
    req_addr     = a;
    req_wdata    = d;
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v.st, v.f3, v.addr, v.wd);
    #1 check("vec_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check("vec_en", dmem_en, 1'b1);
    check("vec_we", dmem_we, v.we);
    check("vec_addr", dmem_addr, v.waddr);
    if (v.st) check("vec_wdata", dmem_wdata, v.ewd);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check("vec_en_off", dmem_en, 1'b0);
      check("vec_rsp_valid", rsp_valid, (k == LAT) && !v.st);
      if (k == LAT && !v.st) begin
        check("vec_rsp_func3", rsp_func3, v.f3);
        check("vec_rsp_off", rsp_byte_addr, v.addr[1:0]);
      end
    end
    tick();
  endtask

  logic [2:0]  bf3 [6];
  logic [31:0] bad [6];
  int          wr0;
  int          sz;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_func3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; dmem_ready = 1'b1; fault_ack = 1'b0;

    vt[0]  = '{1'b1, 3'd0, 32'h0000_1003, 32'hAABBCCDD, 4'b1000, 32'hDDDDDDDD, 30'h400, 1'b0};
    vt[1]  = '{1'b1, 3'd1, 32'h0000_1002, 32'h11223344, 4'b1100, 32'h33443344, 30'h400, 1'b0};
    vt[2]  = '{1'b1, 3'd1, 32'h0000_1001, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF, 30'h400, 1'b1};
    vt[3]  = '{1'b1, 3'd1, 32'h0000_1003, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 30'h400, 1'b1};
    vt[4]  = '{1'b1, 3'd2, 32'h0000_2000, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 30'h800, 1'b0};
    vt[5]  = '{1'b1, 3'd2, 32'h0000_2002, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 30'h800, 1'b1};
    vt[6]  = '{1'b1, 3'd7, 32'h0000_2001, 32'h12345678, 4'b1111, 32'h12345678, 30'h800, 1'b1};
    vt[7]  = '{1'b0, 3'd5, 32'h0000_2002, 32'h0,        4'b0000, 32'h0,        30'h800, 1'b0};
    vt[8]  = '{1'b0, 3'd0, 32'h0000_0005, 32'h0,        4'b0000, 32'h0,        30'h1,   1'b0};
    vt[9]  = '{1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0,        4'b0000, 32'h0,        30'h3FFFFFFF, 1'b0};
    vt[10] = '{1'b0, 3'd4, 32'h0000_0007, 32'h0,        4'b0000, 32'h0,        30'h1,   1'b0};
    vt[11] = '{1'b1, 3'd0, 32'h0000_1000, 32'h00000055, 4'b0001, 32'h55555555, 30'h400, 1'b0};
    vt[12] = '{1'b0, 3'd6, 32'h0000_0010, 32'h0,        4'b0000, 32'h0,        30'h4,   1'b0};

    #3;
    check("reset_ctl", {req_ready, dmem_en, dmem_we, rsp_valid, fault}, 0);
    check("reset_data", {dmem_addr, dmem_wdata, fault_addr}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      if (!(TRAP && vt[i].mis)) apply_vec(vt[i]);
    end

    // SW stalled by dmem_ready for three cycles, with a load waiting behind it
    drive(1'b1, 3'd2, 32'h0000_0040, 32'h01020304);
    tick();
    dmem_ready = 1'b0;
    wr0 = wr_cnt;
    drive(1'b0, 3'd2, 32'h0000_0080, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", req_ready, 1'b0);
      check("stall_port", {dmem_en, dmem_we, dmem_addr, dmem_wdata}, {1'b1, 4'hF, 30'h10, 32'h01020304});
      if (k < 2) tick();
    end
    dmem_ready = 1'b1;
    #1 check("stall_release_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check("stall_next", {dmem_en, dmem_we, dmem_addr}, {1'b1, 4'h0, 30'h20});
    repeat (LAT + 2) tick();
    check("stall_one_write", wr_cnt - wr0, 1);

    // back-to-back loads, one per cycle
    bf3[0] = 3'd0; bad[0] = 32'h0000_0201;
    bf3[1] = 3'd1; bad[1] = 32'h0000_0302;
    bf3[2] = 3'd2; bad[2] = 32'h0000_0400;
    bf3[3] = 3'd4; bad[3] = 32'h0000_0503;
    bf3[4] = 3'd5; bad[4] = 32'h0000_0600;
    bf3[5] = 3'd0; bad[5] = 32'h0000_0702;
    for (int c = 0; c < 11; c++) begin
      if (c < 6) begin
        drive(1'b0, bf3[c], bad[c], 32'h0);
        #1 check("b2b_ready", req_ready, 1'b1);
      end else begin
        req_valid = 1'b0;
        #1;
      end
      if (c >= 1 && c <= 6) check("b2b_port", {dmem_en, dmem_addr}, {1'b1, bad[c-1][31:2]});
      if (c >= LAT + 1 && c <= LAT + 6) begin
        check("b2b_rsp_valid", rsp_valid, 1'b1);
        check("b2b_rsp", {rsp_func3, rsp_byte_addr}, {bf3[c-LAT-1], bad[c-LAT-1][1:0]});
      end else begin
        check("b2b_rsp_idle", rsp_valid, 1'b0);
      end
      tick();
    end

    // reset with two loads in flight
    drive(1'b0, 3'd0, 32'h0000_0100, 32'h0);
    tick();
    drive(1'b0, 3'd2, 32'h0000_0104, 32'h0);
    tick();
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ctl", {dmem_en, dmem_we, rsp_valid, req_ready, fault}, 0);
    check("midrst_data", {dmem_addr, dmem_wdata}, 0);
    tick();
    check("midrst_rsp1", rsp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      check("postrst_quiet", {rsp_valid, dmem_en}, 0);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    drive(1'b0, 3'd2, 32'h0000_3001, 32'h0);
    #1 check("trap_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("trap_hold", {fault, dmem_en, req_ready}, {1'b1, 1'b0, 1'b0});
      check("trap_addr", fault_addr, 32'h0000_3001);
      tick();
    end
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
    #1 check("trap_cleared", {fault, req_ready}, {1'b0, 1'b1});
    tick();
`endif

    // randomized traffic with random memory back-pressure
    req_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      dmem_ready = ($urandom_range(0, 9) < 7);
      if (!req_valid || acc_flag) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid    = 1'b1;
          req_is_store = 1'($urandom_range(0, 1));
          req_func3    = 3'($urandom_range(0, 7));
          req_addr     = $urandom;
          req_wdata    = $urandom;
          if (TRAP) begin
            sz = acc_bytes(req_is_store, req_func3);
            req_addr = req_addr - (req_addr % sz);
          end
        end else begin
          req_valid = 1'b0;
        end
      end
      tick();
    end
    req_valid  = 1'b0;
    dmem_ready = 1'b1;
    repeat (LAT + 4) tick();
    check("drain_empty", port_q.size() + rsp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
